// File: rtl/overture_core_p_if.sv
// Program-fetch, input-stream and output-stream signals of the overture core.
interface overture_core_p_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned PC_W   = 8
);
  logic [PC_W-1:0]   prog_addr;
  logic [7:0]        prog_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  // Core side: fetches instructions, consumes input words, produces output words.
  modport master (
    output prog_addr,
    input  prog_data,
    input  in_valid,
    output in_ready,
    input  in_data,
    output out_valid,
    input  out_ready,
    output out_data
  );

  // Environment side: program store, input source and output sink.
  modport slave (
    input  prog_addr,
    output prog_data,
    output in_valid,
    input  in_ready,
    output in_data,
    input  out_valid,
    output out_ready,
    input  out_data
  );
endinterface

// File: rtl/overture_core_p.sv
// Overture core: tiny one-instruction-per-cycle CPU with IMM/CALC/COPY/COND
// opcodes, a stalling I/O port at register index 6 and a RUN/HALT state.
module overture_core_p #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NREG   = 6,
  parameter int unsigned PC_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  overture_core_p_if.master    bus,
  output logic                 halted
);

  typedef enum logic {RUN, HALT} state_t;
  typedef enum logic [1:0] {OP_IMM, OP_CALC, OP_COPY, OP_COND} op_t;

  state_t            state;
  logic [PC_W-1:0]   pc;
  logic [DATA_W-1:0] regs [NREG];

  op_t               op;
  logic [2:0]        src;
  logic [2:0]        dst;
  logic [2:0]        fn;
  logic              active;
  logic              is_copy;
  logic              src_io;
  logic              dst_io;
  logic              halt_op;
  logic              xfer_ok;
  logic              cond_true;
  logic              r3_neg;
  logic              r3_zero;
  logic [DATA_W-1:0] src_val;
  logic [DATA_W-1:0] calc_val;

  assign bus.prog_addr = pc;

  // Decode, operand select, ALU, branch condition and I/O handshake.
  // Handshake outputs are gated by rst so they drop the moment reset asserts.
  always_comb begin
    op      = op_t'(bus.prog_data[7:6]);
    src     = bus.prog_data[5:3];
    dst     = bus.prog_data[2:0];
    fn      = bus.prog_data[2:0];
    active  = rst && (state == RUN);
    is_copy = active && (op == OP_COPY);
    src_io  = (src == 3'd6);
    dst_io  = (dst == 3'd6);
    halt_op = is_copy && (src == 3'd7) && (dst == 3'd7);

    src_val = '0;
    if (src_io) begin
      src_val = bus.in_data;
    end else begin
      for (int unsigned i = 0; i < NREG; i++) begin
        if (src == 3'(i)) src_val = regs[i];
      end
    end

    calc_val = '0;
    case (fn)
      3'd0: calc_val = regs[1] | regs[2];
      3'd1: calc_val = ~(regs[1] & regs[2]);
      3'd2: calc_val = ~(regs[1] | regs[2]);
      3'd3: calc_val = regs[1] & regs[2];
      3'd4: calc_val = regs[1] + regs[2];
      3'd5: calc_val = regs[1] - regs[2];
      3'd6: calc_val = regs[1] << regs[2][2:0];
      3'd7: calc_val = regs[1] >> regs[2][2:0];
      default: calc_val = '0;
    endcase

    r3_neg  = regs[3][DATA_W-1];
    r3_zero = (regs[3] == '0);
    cond_true = 1'b0;
    case (fn)
      3'd0: cond_true = 1'b0;
      3'd1: cond_true = r3_zero;
      3'd2: cond_true = r3_neg;
      3'd3: cond_true = r3_neg || r3_zero;
      3'd4: cond_true = 1'b1;
      3'd5: cond_true = !r3_zero;
      3'd6: cond_true = !r3_neg;
      3'd7: cond_true = !r3_neg && !r3_zero;
      default: cond_true = 1'b0;
    endcase

    bus.in_ready  = is_copy && src_io && (!dst_io || bus.out_ready);
    bus.out_valid = is_copy && dst_io && (!src_io || bus.in_valid);
    bus.out_data  = bus.out_valid ? src_val : '0;

    if (!src_io && !dst_io)    xfer_ok = 1'b1;
    else if (src_io && dst_io) xfer_ok = bus.in_valid && bus.out_ready;
    else if (src_io)           xfer_ok = bus.in_valid;
    else                       xfer_ok = bus.out_ready;
  end

  // RUN/HALT state machine, PC and register file; an incomplete I/O copy stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= RUN;
      halted <= 1'b0;
      pc     <= '0;
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (state == RUN) begin
      case (op)
        OP_IMM: begin
          regs[0] <= DATA_W'(bus.prog_data[5:0]);
          pc      <= pc + PC_W'(1);
        end
        OP_CALC: begin
          regs[3] <= calc_val;
          pc      <= pc + PC_W'(1);
        end
        OP_COPY: begin
          if (halt_op) begin
            state  <= HALT;
            halted <= 1'b1;
          end else if (xfer_ok) begin
            for (int unsigned i = 0; i < NREG; i++) begin
              if (dst == 3'(i)) regs[i] <= src_val;
            end
            pc <= pc + PC_W'(1);
          end
        end
        OP_COND: begin
          pc <= cond_true ? PC_W'(regs[0]) : pc + PC_W'(1);
        end
        default: pc <= pc;
      endcase
    end
  end

endmodule

// File: tb/tb_overture_core_p.sv
// Scoreboard bench for overture_core_p: expected output words are queued as
// programs are loaded and compared when the core completes an output transfer.
module tb_overture_core_p;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned NREG   = 6;
  localparam int unsigned PC_W   = 8;

  logic clk;
  logic rst;
  logic halted;
  logic [7:0] mem [256];
  logic [7:0] sb [$];
  int n_err;
  int n_chk;
  int n_push;
  int n_out;

  overture_core_p_if #(.DATA_W(DATA_W), .PC_W(PC_W)) bus ();

  overture_core_p #(.DATA_W(DATA_W), .NREG(NREG), .PC_W(PC_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .halted (halted)
  );

  assign bus.prog_data = mem[bus.prog_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] f_imm(input logic [5:0] v);
    return {2'b00, v};
  endfunction
  function automatic logic [7:0] f_calc(input logic [2:0] f);
    return {2'b01, 3'b000, f};
  endfunction
  function automatic logic [7:0] f_cp(input logic [2:0] s, input logic [2:0] d);
    return {2'b10, s, d};
  endfunction
  function automatic logic [7:0] f_cond(input logic [2:0] c);
    return {2'b11, 3'b000, c};
  endfunction

  task automatic push_exp(input logic [7:0] v);
    sb.push_back(v);
    n_push++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Output monitor: every completed output transfer must match the queue head.
  always @(negedge clk) begin
    if (bus.out_valid && bus.out_ready) begin
      n_out++;
      if (sb.size() > 0) check_eq("out_data", bus.out_data, sb.pop_front());
      else check_eq("out_extra", n_out, n_push);
    end
  end

  task automatic start_test();
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 8'hBF;
  endtask

  task automatic release_rst(input string tag);
    #1;
    check_eq({tag, "_rst_pc"}, bus.prog_addr, 0);
    check_eq({tag, "_rst_in_ready"}, bus.in_ready, 0);
    check_eq({tag, "_rst_out_valid"}, bus.out_valid, 0);
    check_eq({tag, "_rst_out_data"}, bus.out_data, 0);
    check_eq({tag, "_rst_halted"}, halted, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
  endtask

  task automatic run_to(input logic [7:0] addr, input int budget, input string tag);
    for (int i = 0; i < budget && bus.prog_addr !== addr; i++) step();
    check_eq(tag, bus.prog_addr, addr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_err = 0; n_chk = 0; n_push = 0; n_out = 0;
    rst = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;

    // T1: ALU functions, COPY from index 7, halt then asynchronous reset in HALT.
    start_test();
    mem[0] = f_imm(6'h3F); mem[1] = f_cp(0, 1); mem[2] = f_imm(6'h05); mem[3] = f_cp(0, 2);
    mem[4] = f_calc(5);  mem[5] = f_cp(3, 6);
    mem[6] = f_calc(6);  mem[7] = f_cp(3, 6);
    mem[8] = f_calc(4);  mem[9] = f_cp(3, 6);
    mem[10] = f_calc(1); mem[11] = f_cp(3, 6);
    mem[12] = f_calc(0); mem[13] = f_cp(3, 6);
    mem[14] = f_calc(3); mem[15] = f_cp(3, 6);
    mem[16] = f_calc(7); mem[17] = f_cp(3, 6);
    mem[18] = f_calc(2); mem[19] = f_cp(3, 6);
    mem[20] = f_cp(7, 0); mem[21] = f_cp(0, 6);
    mem[22] = f_cp(7, 7);
    push_exp(8'd58); push_exp(8'hE0); push_exp(8'h44); push_exp(8'hFA);
    push_exp(8'h3F); push_exp(8'h05); push_exp(8'h01); push_exp(8'hC0);
    push_exp(8'h00);
    release_rst("t1");
    run_to(8'd22, 100, "t1_reach_halt_pc");
    check_eq("t1_not_halted_yet", halted, 0);
    step();
    check_eq("t1_halted", halted, 1);
    check_eq("t1_halt_pc", bus.prog_addr, 22);
    step(); step(); step();
    check_eq("t1_halt_pc_frozen", bus.prog_addr, 22);
    check_eq("t1_halt_out_valid", bus.out_valid, 0);
    check_eq("t1_sb_drained", sb.size(), 0);
    #2;
    rst = 1'b0;
    #1;
    check_eq("t1_async_halted", halted, 0);
    check_eq("t1_async_pc", bus.prog_addr, 0);

    // T2: input stall for three cycles, then handshake loads r1.
    start_test();
    mem[0] = f_cp(6, 1); mem[1] = f_cp(1, 6); mem[2] = f_cp(7, 7);
    push_exp(8'h9A);
    release_rst("t2");
    for (int i = 0; i < 3; i++) begin
      check_eq("t2_stall_pc", bus.prog_addr, 0);
      check_eq("t2_in_ready", bus.in_ready, 1);
      step();
    end
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h9A;
    step();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    check_eq("t2_pc_after_in", bus.prog_addr, 1);
    run_to(8'd2, 10, "t2_reach_halt_pc");
    step();
    check_eq("t2_halted", halted, 1);
    check_eq("t2_sb_drained", sb.size(), 0);

    // T3: pass-through copy 6->6 held off by out_ready.
    start_test();
    mem[0] = f_cp(6, 6); mem[1] = f_cp(7, 7);
    release_rst("t3");
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h5C;
    bus.out_ready = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check_eq("t3_in_ready_low", bus.in_ready, 0);
      check_eq("t3_out_valid", bus.out_valid, 1);
      check_eq("t3_out_data", bus.out_data, 8'h5C);
      check_eq("t3_stall_pc", bus.prog_addr, 0);
      step();
    end
    push_exp(8'h5C);
    bus.out_ready = 1'b1;
    #1;
    check_eq("t3_in_ready_high", bus.in_ready, 1);
    step();
    bus.in_valid = 1'b0;
    check_eq("t3_pc_after", bus.prog_addr, 1);
    check_eq("t3_out_valid_after", bus.out_valid, 0);
    step();
    check_eq("t3_halted", halted, 1);
    check_eq("t3_sb_drained", sb.size(), 0);

    // T4: signed branch conditions and PC wrap from 0xFF to 0x00.
    start_test();
    mem[0] = f_imm(6'd1); mem[1] = f_cp(0, 1); mem[2] = f_imm(6'd7); mem[3] = f_cp(0, 2);
    mem[4] = f_calc(6); mem[5] = f_imm(6'h10); mem[6] = f_cond(2);
    mem[8'h10] = f_cond(7); mem[8'h11] = f_cp(3, 6);
    mem[8'h12] = f_imm(6'd0); mem[8'h13] = f_cp(0, 1); mem[8'h14] = f_cp(0, 2);
    mem[8'h15] = f_calc(2); mem[8'h16] = f_cp(3, 0); mem[8'h17] = f_cond(4);
    mem[8'hFF] = f_cp(0, 6);
    push_exp(8'h80); push_exp(8'hFF);
    release_rst("t4");
    for (int i = 0; i < 7; i++) step();
    check_eq("t4_cond_lt_taken", bus.prog_addr, 8'h10);
    step();
    check_eq("t4_cond_gt_not_taken", bus.prog_addr, 8'h11);
    step();
    check_eq("t4_after_out", bus.prog_addr, 8'h12);
    for (int i = 0; i < 6; i++) step();
    check_eq("t4_cond_always", bus.prog_addr, 8'hFF);
    step();
    check_eq("t4_pc_wrap", bus.prog_addr, 8'h00);
    check_eq("t4_sb_drained", sb.size(), 0);

    // T5: reset during an output stall abandons the transfer and restarts at 0.
    start_test();
    mem[0] = f_imm(6'h15); mem[1] = f_cp(0, 6); mem[2] = f_cp(7, 7);
    release_rst("t5");
    bus.out_ready = 1'b0;
    step();
    check_eq("t5_out_valid", bus.out_valid, 1);
    check_eq("t5_out_data", bus.out_data, 8'h15);
    step();
    check_eq("t5_stall_pc", bus.prog_addr, 1);
    #2;
    rst = 1'b0;
    #1;
    check_eq("t5_rst_out_valid", bus.out_valid, 0);
    check_eq("t5_rst_out_data", bus.out_data, 0);
    check_eq("t5_rst_pc", bus.prog_addr, 0);
    push_exp(8'h15);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_eq("t5_restart_pc", bus.prog_addr, 0);
    step();
    check_eq("t5_pc1", bus.prog_addr, 1);
    step();
    check_eq("t5_pc2", bus.prog_addr, 2);
    step();
    check_eq("t5_halted", halted, 1);
    check_eq("t5_sb_drained", sb.size(), 0);
    check_eq("out_count", n_out, n_push);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/overture_core_p.md
OVERTURE_CORE_P -- requirements
Module: overture_core_p

Interface
REQ-001 SHALL provide parameter DATA_W, default 8, register/ALU/I-O data width (range 8..32).
REQ-002 SHALL provide parameter NREG, default 6, implemented general registers r0..r(NREG-1) (range 4..6).
REQ-003 SHALL provide parameter PC_W, default 8, program-counter width (range 4..16).
REQ-004 SHALL provide port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL provide port rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-006 SHALL provide port prog_addr  output  PC_W  current PC, driven straight from PC register.
REQ-007 SHALL provide port prog_data  input  8  instruction at prog_addr, combinational same-cycle read.
REQ-008 SHALL provide port in_valid  input  1  external input word available.
REQ-009 SHALL provide port in_ready  output  1  core consumes input this cycle.
REQ-010 SHALL provide port in_data  input  DATA_W  input word.
REQ-011 SHALL provide port out_valid  output  1  core presents output word.
REQ-012 SHALL provide port out_ready  input  1  sink accepts output.
REQ-013 SHALL provide port out_data  output  DATA_W  output word.
REQ-014 SHALL provide port halted  output  1  core in HALT state.

Function
REQ-015 SHALL decode prog_data[7:6]: 00 IMM, 01 CALC, 10 COPY, 11 COND; one instruction per cycle unless stalled.
REQ-016 SHALL on IMM write zero-extended prog_data[5:0] to r0.
REQ-017 SHALL on CALC write r3 <= f(r1,r2), f by prog_data[2:0]: 0 OR, 1 NAND, 2 NOR, 3 AND, 4 ADD, 5 SUB (r1-r2), 6 SHL (r1<<r2[2:0]), 7 SHR logical (r1>>r2[2:0]); result truncated to DATA_W, carry discarded.
REQ-018 SHALL on COPY move src=prog_data[5:3] to dst=prog_data[2:0]; index 6 = I/O port; index 7 and indexes >=NREG (excluding 6) read 0, writes discarded.
REQ-019 SHALL on COND evaluate r3 as signed DATA_W by prog_data[2:0]: 0 never, 1 =0, 2 <0, 3 <=0, 4 always, 5 !=0, 6 >=0, 7 >0; if true PC <= r0 truncated/zero-extended to PC_W, else PC+1.
REQ-020 SHALL advance PC by 1 modulo 2^PC_W for every completed non-jump instruction; PC wraps from all-ones to 0.
REQ-021 SHALL for COPY src=6 drive in_ready=1 iff (dst!=6 or out_ready); instruction completes on in_valid&in_ready.
REQ-022 SHALL for COPY dst=6 drive out_valid=1, out_data=source value iff (src!=6 or in_valid); completes on out_valid&out_ready.
REQ-023 SHALL for COPY 6->6 complete only when in_valid and out_ready are high in the same cycle; out_data=in_data.
REQ-024 SHALL hold PC and all registers unchanged while an I/O instruction is incomplete (stall); no limit on stall length.
REQ-025 SHALL drive in_ready=0 and out_valid=0 for every non-I/O instruction and in HALT; out_data=0 when out_valid=0.
REQ-026 SHALL implement FSM RUN/HALT: COPY 7->7 in RUN moves to HALT at the edge; PC not incremented; HALT exits only via reset.
REQ-027 SHALL in HALT freeze PC and registers, assert halted=1, ignore prog_data.
REQ-028 SHALL treat r0 write and branch in same instruction impossible (disjoint opcodes); COND reads pre-edge r0/r3.

Reset
REQ-029 SHALL on rst=0 immediately clear PC, r0..r(NREG-1), state=RUN; outputs prog_addr=0, in_ready=0, out_valid=0, out_data=0, halted=0.
REQ-030 SHALL on reset mid-stall abandon the pending I/O transfer with no register write; first instruction after release fetched from address 0.

Verification
REQ-031 SHALL cover: IMM 63 (0x3F), COPY r0->r1, IMM 5, COPY r0->r2, CALC SUB -> r3=58; CALC SHL with r2=5 -> r3=r1<<5 truncated (DATA_W=8: 0x3F<<5=0xE0).
REQ-032 SHALL cover: COPY 6->r1 with in_valid low 3 cycles then high, in_data=0x9A -> prog_addr held 3 cycles, r1=0x9A, PC+1 after handshake.
REQ-033 SHALL cover: COPY 6->6 with in_valid high, out_ready low 2 cycles -> in_ready=0, PC held; both high -> out_data=in_data, single transfer.
REQ-034 SHALL cover: r3=0x80 (DATA_W=8), r0=0x10, COND <0 -> PC=0x10; COND >0 -> PC+1; PC=0xFF non-jump -> PC=0x00.
REQ-035 SHALL cover: COPY 7->7 -> halted=1 next cycle, PC frozen; rst=0 mid-HALT -> halted=0, PC=0 asynchronously.
REQ-036 SHALL cover: rst=0 during out_valid stall -> out_valid drops at once, no register changed, restart at PC 0.
